// File: rtl/vip_stream_pkg.sv
// ----------------------------------------------------------------------------
// vip_stream_pkg
// Shared types and constants for the frame-timing / test-pattern source:
//   - pat_e   : luma pattern selector encodings
//   - state_e : frame state machine encoding
//   - CNT_W   : width of the horizontal / vertical position counters
//   - in_span : half-open range test used by the region decoder
// ----------------------------------------------------------------------------
package vip_stream_pkg;

    localparam int CNT_W  = 12;
    localparam int FCNT_W = 8;

    typedef enum logic [1:0] {
        PAT_HRAMP = 2'd0,
        PAT_VRAMP = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_FCNT  = 2'd3
    } pat_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // True when lo <= v < hi.
    function automatic logic in_span(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vip_pattern_lut.sv
// ----------------------------------------------------------------------------
// vip_pattern_lut
// Combinational luma generator for the active picture area.
// Ports:
//   x_i         in  8  low byte of the active-area column index
//   y_i         in  8  low byte of the active-area row index
//   frame_cnt_i in  8  frame counter of the frame being emitted
//   pat_i       in  2  pattern selector latched for the current frame
//   y_o         out 8  pixel luma
// ----------------------------------------------------------------------------
module vip_pattern_lut
    import vip_stream_pkg::*;
(
    input  logic [7:0] x_i,
    input  logic [7:0] y_i,
    input  logic [7:0] frame_cnt_i,
    input  logic [1:0] pat_i,
    output logic [7:0] y_o
);

    always_comb begin
        y_o = '0;
        case (pat_e'(pat_i))
            PAT_HRAMP: y_o = x_i;
            PAT_VRAMP: y_o = y_i;
            // 8x8 tiles: bit 3 of each coordinate flips every 8 pixels/lines.
            PAT_CHECK: y_o = (x_i[3] ^ y_i[3]) ? 8'hFF : 8'h00;
            PAT_FCNT:  y_o = frame_cnt_i;
            default:   y_o = '0;
        endcase
    end

endmodule

// File: rtl/vip_frame_stream_gen.sv
// ----------------------------------------------------------------------------
// vip_frame_stream_gen
// Frame-timing and test-pattern source for the per_frame_* / per_img_Y stream.
// Position counters run only while a frame is in progress; every output is
// registered from a decode of the counters, so all outputs share one clock of
// latency and stay mutually aligned.
// Ports:
//   clk             in  1  pixel clock
//   rst             in  1  asynchronous active-high reset
//   enable          in  1  run request, sampled only at frame boundaries
//   pattern_sel     in  2  0 h-ramp, 1 v-ramp, 2 checkerboard 8x8, 3 frame count
//   per_frame_vsync out 1  high during the V_SYNC lines of a running frame
//   per_frame_hsync out 1  high for the first H_SYNC clocks of every line
//   per_frame_href  out 1  high for active pixels of active lines
//   per_img_Y       out 8  pixel luma, 0 whenever href is low
//   frame_done      out 1  one-clock pulse on the last clock of each frame
//   busy            out 1  high while a frame is in progress
// ----------------------------------------------------------------------------
module vip_frame_stream_gen
    import vip_stream_pkg::*;
#(
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 20,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 10,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    output logic       per_frame_vsync,
    output logic       per_frame_hsync,
    output logic       per_frame_href,
    output logic [7:0] per_img_Y,
    output logic       frame_done,
    output logic       busy
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_E  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_E  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_B   = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_ACT_E   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_B   = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_ACT_E   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0]    v_cnt_q, v_cnt_d;
    logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [1:0]          pat_q, pat_d;

    logic                line_end, frame_end, run;
    logic [7:0]          x_lo, y_lo, lut_y;

    logic                vsync_d, hsync_d, href_d, fdone_d, busy_d;
    logic [7:0]          y_d;

    assign run       = (state_q == RUN);
    assign line_end  = (h_cnt_q == H_LAST);
    assign frame_end = line_end && (v_cnt_q == V_LAST);

    // ------------------------------------------------------------------
    // Frame state machine and position counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            frame_cnt_q <= '0;
            pat_q       <= '0;
        end else begin
            state_q     <= state_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            pat_q       <= pat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        frame_cnt_d = frame_cnt_q;
        pat_d       = pat_q;
        case (state_q)
            IDLE: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                if (enable) begin
                    state_d = RUN;
                    pat_d   = pattern_sel;
                end
            end
            RUN: begin
                if (line_end) begin
                    h_cnt_d = '0;
                    v_cnt_d = frame_end ? '0 : v_cnt_q + CNT_W'(1);
                end else begin
                    h_cnt_d = h_cnt_q + CNT_W'(1);
                end
                // enable and pattern_sel only matter here, so a frame always
                // completes and keeps one pattern from start to end.
                if (frame_end) begin
                    frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                    if (enable) begin
                        pat_d = pattern_sel;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Region decode and pattern lookup
    // ------------------------------------------------------------------
    // Only the low byte of the active-area coordinates feeds the patterns;
    // the low byte of the difference equals the difference of low bytes.
    assign x_lo = h_cnt_q[7:0] - H_ACT_B[7:0];
    assign y_lo = v_cnt_q[7:0] - V_ACT_B[7:0];

    vip_pattern_lut u_lut (
        .x_i         (x_lo),
        .y_i         (y_lo),
        .frame_cnt_i (frame_cnt_q),
        .pat_i       (pat_q),
        .y_o         (lut_y)
    );

    always_comb begin
        vsync_d = run && (v_cnt_q < V_SYNC_E);
        hsync_d = run && (h_cnt_q < H_SYNC_E);
        href_d  = run && in_span(h_cnt_q, H_ACT_B, H_ACT_E)
                      && in_span(v_cnt_q, V_ACT_B, V_ACT_E);
        y_d     = href_d ? lut_y : 8'd0;
        fdone_d = run && frame_end;
        busy_d  = run;
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_frame_vsync <= 1'b0;
            per_frame_hsync <= 1'b0;
            per_frame_href  <= 1'b0;
            per_img_Y       <= 8'd0;
            frame_done      <= 1'b0;
            busy            <= 1'b0;
        end else begin
            per_frame_vsync <= vsync_d;
            per_frame_hsync <= hsync_d;
            per_frame_href  <= href_d;
            per_img_Y       <= y_d;
            frame_done      <= fdone_d;
            busy            <= busy_d;
        end
    end

endmodule

// File: tb/tb_vip_frame_stream_gen.sv
// ----------------------------------------------------------------------------
// tb_vip_frame_stream_gen
// Two instances share clock, reset and controls: one with 8 active pixels per
// line, one with 16 so the 8x8 checkerboard shows both tile colours. A model
// based on a linear position within the frame pushes the expected outputs of
// every clock into per-instance queues; a negedge monitor pops and compares.
// ----------------------------------------------------------------------------
module tb_vip_frame_stream_gen;

    localparam int HS  = 2;
    localparam int HBP = 2;
    localparam int HFP = 2;
    localparam int HA0 = 8;
    localparam int HA1 = 16;
    localparam int VS  = 1;
    localparam int VBP = 1;
    localparam int VA  = 4;
    localparam int VFP = 1;
    localparam int VT  = VS + VBP + VA + VFP;
    localparam int HT0 = HS + HBP + HA0 + HFP;

    typedef struct packed {
        logic       vs;
        logic       hs;
        logic       hr;
        logic [7:0] y;
        logic       fd;
        logic       bz;
    } obs_t;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [1:0] pattern_sel;

    logic       vs0, hs0, hr0, fd0, bz0;
    logic [7:0] y0;
    logic       vs1, hs1, hr1, fd1, bz1;
    logic [7:0] y1;

    int n_tests = 0;
    int n_fail  = 0;

    vip_frame_stream_gen #(
        .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA0), .H_FP(HFP),
        .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP)
    ) dut0 (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .pattern_sel     (pattern_sel),
        .per_frame_vsync (vs0),
        .per_frame_hsync (hs0),
        .per_frame_href  (hr0),
        .per_img_Y       (y0),
        .frame_done      (fd0),
        .busy            (bz0)
    );

    vip_frame_stream_gen #(
        .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA1), .H_FP(HFP),
        .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP)
    ) dut1 (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .pattern_sel     (pattern_sel),
        .per_frame_vsync (vs1),
        .per_frame_hsync (hs1),
        .per_frame_href  (hr1),
        .per_img_Y       (y1),
        .frame_done      (fd1),
        .busy            (bz1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs for linear frame position cp (-1 means no frame).
    function automatic obs_t decode(input int cp, input int pat, input int fc, input int ha);
        obs_t o;
        int ht, h, v, px, py;
        o = '0;
        if (cp < 0) return o;
        ht = HS + HBP + ha + HFP;
        h  = cp % ht;
        v  = cp / ht;
        px = h - (HS + HBP);
        py = v - (VS + VBP);
        o.bz = 1'b1;
        o.vs = (v < VS);
        o.hs = (h < HS);
        o.hr = (px >= 0) && (px < ha) && (py >= 0) && (py < VA);
        o.fd = (cp == ht * VT - 1);
        if (o.hr) begin
            case (pat)
                0:       o.y = 8'(px % 256);
                1:       o.y = 8'(py % 256);
                2:       o.y = (((px / 8) + (py / 8)) % 2 == 1) ? 8'hFF : 8'h00;
                default: o.y = 8'(fc);
            endcase
        end
        return o;
    endfunction

    function automatic int ha_of(input int d);
        return (d == 0) ? HA0 : HA1;
    endfunction

    // Reference model state per instance.
    int   cp   [2];
    int   mpat [2];
    int   fc   [2];
    obs_t q0 [$];
    obs_t q1 [$];
    bit   chk_en = 1'b0;
    obs_t e_m;
    int   last_m;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                cp[d]   = -1;
                mpat[d] = 0;
                fc[d]   = 0;
            end
            q0.delete();
            q1.delete();
            q0.push_back('0);
            q1.push_back('0);
        end else begin
            for (int d = 0; d < 2; d++) begin
                e_m = decode(cp[d], mpat[d], fc[d], ha_of(d));
                if (d == 0) q0.push_back(e_m);
                else        q1.push_back(e_m);
                last_m = (HS + HBP + ha_of(d) + HFP) * VT - 1;
                if (cp[d] < 0) begin
                    if (enable) begin
                        cp[d]   = 0;
                        mpat[d] = int'(pattern_sel);
                    end
                end else if (cp[d] == last_m) begin
                    fc[d] = (fc[d] + 1) % 256;
                    if (enable) begin
                        cp[d]   = 0;
                        mpat[d] = int'(pattern_sel);
                    end else begin
                        cp[d] = -1;
                    end
                end else begin
                    cp[d] = cp[d] + 1;
                end
            end
        end
        chk_en = 1'b1;
    end

    task automatic check_obs(input string nm, input obs_t a, input obs_t e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s @%0t got vs=%b hs=%b href=%b Y=%0d fd=%b busy=%b expected vs=%b hs=%b href=%b Y=%0d fd=%b busy=%b",
                     nm, $time, a.vs, a.hs, a.hr, a.y, a.fd, a.bz,
                     e.vs, e.hs, e.hr, e.y, e.fd, e.bz);
        end
    endtask

    task automatic cmp_int(input string nm, input int a, input int e);
        n_tests++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s @%0t got %0d expected %0d", nm, $time, a, e);
        end
    endtask

    // Monitor: per-clock scoreboard plus whole-frame output counts.
    obs_t a0, a1, x0, x1;
    int   hr_n = 0, vs_n = 0, hs_r = 0;
    logic hs_prev = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            a0 = {vs0, hs0, hr0, y0, fd0, bz0};
            a1 = {vs1, hs1, hr1, y1, fd1, bz1};
            if (q0.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL dut8 no expected entry @%0t", $time);
            end else begin
                x0 = q0.pop_front();
                check_obs("dut8", a0, x0);
            end
            if (q1.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL dut16 no expected entry @%0t", $time);
            end else begin
                x1 = q1.pop_front();
                check_obs("dut16", a1, x1);
            end
            if (rst) begin
                hr_n = 0; vs_n = 0; hs_r = 0; hs_prev = 1'b0;
            end else begin
                hr_n += int'(hr0);
                vs_n += int'(vs0);
                if (hs0 && !hs_prev) hs_r++;
                hs_prev = hs0;
                if (fd0) begin
                    cmp_int("href clocks per frame", hr_n, HA0 * VA);
                    cmp_int("vsync clocks per frame", vs_n, VS * HT0);
                    cmp_int("hsync pulses per frame", hs_r, VT);
                    hr_n = 0; vs_n = 0; hs_r = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_cp(input int target);
        int n;
        n = 0;
        while (cp[0] != target && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) begin
            n_tests++; n_fail++;
            $display("FAIL wait for frame position %0d timed out, at %0d", target, cp[0]);
        end
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        pattern_sel = 2'd0;
        repeat (3) tick();
        cmp_int("reset outputs dut8", int'({vs0, hs0, hr0, y0, fd0, bz0}), 0);
        cmp_int("reset outputs dut16", int'({vs1, hs1, hr1, y1, fd1, bz1}), 0);
        rst = 1'b0;
        repeat (4) tick();

        // Back-to-back horizontal ramp frames.
        enable = 1'b1;
        pattern_sel = 2'd0;
        repeat (3 * 98 + 4) tick();

        // Vertical ramp.
        pattern_sel = 2'd1;
        repeat (2 * 98) tick();

        // Ramp frame, then switch to checkerboard mid-frame.
        pattern_sel = 2'd0;
        wait_cp(97);
        tick();
        wait_cp(40);
        pattern_sel = 2'd2;
        repeat (3 * 98) tick();

        // Drop enable at clock 30: frame completes then the block idles.
        wait_cp(30);
        enable = 1'b0;
        repeat (150) tick();

        // Reset in the middle of an active line.
        enable = 1'b1;
        pattern_sel = 2'd0;
        wait_cp(50);
        rst = 1'b1;
        #1;
        cmp_int("async reset outputs dut8", int'({vs0, hs0, hr0, y0, fd0, bz0}), 0);
        cmp_int("async reset outputs dut16", int'({vs1, hs1, hr1, y1, fd1, bz1}), 0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (2 * 98) tick();

        // Randomized enable / pattern / reset activity.
        for (int seg = 0; seg < 30; seg++) begin
            enable      = ($urandom_range(0, 3) != 0);
            pattern_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                repeat (2) tick();
                rst = 1'b0;
            end
            for (int k = 0; k < int'($urandom_range(5, 200)); k++) begin
                if ($urandom_range(0, 15) == 0) pattern_sel = 2'($urandom_range(0, 3));
                tick();
            end
        end

        // Frame-count pattern from a fresh reset, long enough to wrap 255 -> 0.
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        enable = 1'b1;
        pattern_sel = 2'd3;
        repeat (257 * 98 + 20) tick();
        enable = 1'b0;
        repeat (400) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vip_frame_stream_gen.md
Name: vip_frame_stream_gen

Overview:
- Frame-timing and test-pattern source that drives the per_frame_vsync / per_frame_href / per_frame_hsync / per_img_Y stream.
- This is the same stream consumed by the 3x3 matrix generator and the downstream ISP filters.
- Used as the bring-up and verification stimulus source at the head of the ISP pipeline, and as a drop-in camera replacement.
- Generates programmable blanking, sync and active regions, plus selectable 8-bit luma patterns.

Parameters:
H_SYNC, 4, hsync width in clocks at the start of every line
H_BP, 20, clocks from hsync end to first active pixel
H_ACTIVE, 640, active pixels per line (max 2048)
H_FP, 16, clocks after last active pixel to line end
V_SYNC, 2, vsync width in lines at the start of every frame
V_BP, 10, lines from vsync end to first active line
V_ACTIVE, 480, active lines per frame (max 2048)
V_FP, 5, lines after last active line to frame end

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous active-high reset
enable  in  1  run request; sampled only at frame boundaries
pattern_sel  in  2  0 h-ramp, 1 v-ramp, 2 checkerboard 8x8, 3 frame-count flat
per_frame_vsync  out  1  frame sync, high during V_SYNC lines
per_frame_hsync  out  1  line sync, high for first H_SYNC clocks of every line in a running frame
per_frame_href  out  1  pixel valid, high for active pixels of active lines
per_img_Y  out  8  pixel luma; 0 whenever href low
frame_done  out  1  one-clock pulse on the last clock of each frame
busy  out  1  high while a frame is in progress

Behaviour:
- One clock, clk; reset rst is asynchronous and active-high. All outputs are registered.
- Reset values:
  - all outputs 0.
  - h_cnt = 0, v_cnt = 0, frame_cnt = 0; state IDLE.
- Derived constants: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP.
- Counter widths: 12-bit h_cnt and v_cnt, 8-bit frame_cnt.
- State machine IDLE / RUN:
  - IDLE: h_cnt and v_cnt are held at 0, all stream outputs are 0. On enable=1, go to RUN next clock and latch pattern_sel into pat_q.
  - RUN: h_cnt increments every clock and wraps at H_TOTAL-1, at which point v_cnt increments. v_cnt wraps at V_TOTAL-1.
  - End of frame (h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1): pulse frame_done and increment frame_cnt (mod 256).
    - If enable=1, continue into the next frame and re-latch pattern_sel.
    - If enable=0, go to IDLE.
- Mid-frame changes: enable deasserting mid-frame does not truncate the frame; it always completes. pattern_sel changes mid-frame are ignored.
- Region decode (registered, one clock after the counters; the counter-to-output skew is internal and not visible):
  - vsync = RUN and v_cnt < V_SYNC.
  - hsync = RUN and h_cnt < H_SYNC.
  - href = RUN and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1] and h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1].
- Pattern generation, with x = h_cnt-(H_SYNC+H_BP) and y = v_cnt-(V_SYNC+V_BP):
  - 0: Y = x[7:0]
  - 1: Y = y[7:0]
  - 2: Y = (x[3]^y[3]) ? 8'hFF : 8'h00
  - 3: Y = frame_cnt of the current frame (latched at frame start)
  - per_img_Y is valid in the same clock as per_frame_href.
- busy = 1 from the first RUN clock through the frame_done clock inclusive.
- Output counts:
  - href is high exactly H_ACTIVE consecutive clocks per active line and V_ACTIVE lines per frame.
  - hsync pulses V_TOTAL times per frame.
- Reset asserted mid-frame: all outputs drop to 0 asynchronously. After release the block starts a fresh frame from v_cnt=0 when enable=1. No partial line is emitted.
- enable held high: frames are back-to-back with no idle clock; vsync of frame N+1 follows the frame_done of frame N on the next clock.

Decomposition:
- Package vip_stream_pkg:
  - pattern_sel encodings PAT_HRAMP=0, PAT_VRAMP=1, PAT_CHECK=2, PAT_FCNT=3.
  - state encoding IDLE/RUN.
  - counter width constant CNT_W=12.
- Sub-module vip_pattern_lut: combinational x, y, frame_cnt, pat_q -> Y. The top level holds the counters, FSM and output registers.

Test Plan:
All scenarios use H_SYNC=2, H_BP=2, H_ACTIVE=8, H_FP=2 (H_TOTAL=14) and V_SYNC=1, V_BP=1, V_ACTIVE=4, V_FP=1 (V_TOTAL=7 lines, 98 clocks).
- enable=1 held, pattern 0:
  - frame_done pulses every 98 clocks.
  - vsync high 14 clocks per frame.
  - 4 href bursts of 8 clocks with Y=0..7; 7 hsync pulses of 2 clocks each.
- Pattern 1: active lines carry Y=0,1,2,3 (constant across each line). Pattern 2 with H_ACTIVE=16: line 0 reads 8x00 then 8xFF.
- Pattern 3 over 3 frames: Y=0, then 1, then 2 in successive frames; frame_cnt wraps 255->0 after 256 frames.
- enable dropped at clock 30 of a frame: the frame completes, frame_done fires at clock 97, busy falls next clock, outputs stay 0 thereafter.
- pattern_sel switched 0->2 mid-frame: current frame stays a ramp; the next frame is a checkerboard.
- rst pulsed at clock 50 (mid href): outputs 0 in the same cycle. After release with enable=1, vsync is the first asserted output and the first href appears 2 lines later.
